// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// Words arrive over a valid/ready handshake; the line idles high.
module piso_serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             done
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_baud;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic             w_baud_last;
  logic [WIDTH-1:0] w_shreg_next;

  assign w_baud_last  = (r_baud == BAUD_LAST);
  assign w_shreg_next = r_shreg >> 1;

  assign in_ready = (r_state == S_IDLE) && enable && !reset;
  assign tx_out   = r_tx;
  assign tx_busy  = r_busy;
  assign done     = r_done;

  // tx_out is computed from the next state so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shreg   <= in_data;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shreg[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shreg <= w_shreg_next;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_tx      <= w_shreg_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
